pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 151 +++++++++++++++
 tb/tb_pipeline_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - pipeline hazard/flush/stall control FSM
//
// Purpose: sequences stalls for memory waits and multi-cycle execute ops,
// and PC reload plus pipeline flushes for taken branches and exceptions.
// All state updates on the falling edge of clock; reset is asynchronous, active-high.
//
// Ports:
//   clock, reset                      clock / async active-high reset
//   branch_taken, exception_req       redirect requests (branch honoured only in RUN)
//   multi_start, multi_cycles         extra execute cycles request
//   mem_ready                         memory access completes this cycle
//   stall, fetch_enable, pc_load      pipeline control outputs
//   flush_decode, flush_execute       pipeline register flushes
//   state                             current FSM state code (debug)
//   perf_stall_count, perf_flush_count  saturating perf counters, present only
//                                       when GBA_PIPE_PERF_EN is defined
module pipeline_controller #(
  parameter int MULTI_WIDTH = 4,
  parameter int PERF_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   branch_taken,
  input  logic                   exception_req,
  input  logic                   multi_start,
  input  logic [MULTI_WIDTH-1:0] multi_cycles,
  input  logic                   mem_ready,
  output logic                   stall,
  output logic                   fetch_enable,
  output logic                   pc_load,
  output logic                   flush_decode,
  output logic                   flush_execute,
  output logic [2:0]             state
`ifdef GBA_PIPE_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]  perf_stall_count,
  output logic [PERF_WIDTH-1:0]  perf_flush_count
`endif
);

  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] MEMWAIT = 3'd1;
  localparam logic [2:0] MULTI   = 3'd2;
  localparam logic [2:0] REFILL1 = 3'd3;
  localparam logic [2:0] REFILL2 = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [MULTI_WIDTH-1:0] cnt_q, cnt_d;
  logic                   exc_pending_q, exc_pending_d;
  logic                   stall_c, fetch_c, pc_load_c, flush_d_c, flush_x_c;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    exc_pending_d = exc_pending_q;
    stall_c       = 1'b0;
    fetch_c       = 1'b0;
    pc_load_c     = 1'b0;
    flush_d_c     = 1'b0;
    flush_x_c     = 1'b0;
    case (state_q)
      RUN: begin
        fetch_c = 1'b1;
        if (exc_pending_q || exception_req || branch_taken) begin
          pc_load_c     = 1'b1;
          flush_d_c     = 1'b1;
          flush_x_c     = 1'b1;
          exc_pending_d = 1'b0;
          state_d       = REFILL1;
        end else if (!mem_ready) begin
          stall_c = 1'b1;
          fetch_c = 1'b0;
          state_d = MEMWAIT;
        end else if (multi_start && (multi_cycles != '0)) begin
          cnt_d   = multi_cycles;
          state_d = MULTI;
        end
      end
      MEMWAIT: begin
        stall_c = 1'b1;
        if (mem_ready) state_d = RUN;
      end
      MULTI: begin
        // Counter only advances on cycles where the bus is not holding us,
        // so a bus wait lengthens the stall rather than eating into it.
        stall_c = 1'b1;
        if (mem_ready) begin
          cnt_d = cnt_q - MULTI_WIDTH'(1);
          if (cnt_q == MULTI_WIDTH'(1)) state_d = RUN;
        end
      end
      REFILL1: begin
        fetch_c   = 1'b1;
        flush_x_c = 1'b1;
        stall_c   = !mem_ready;
        if (mem_ready) state_d = REFILL2;
      end
      REFILL2: begin
        fetch_c = 1'b1;
        stall_c = !mem_ready;
        if (mem_ready) state_d = RUN;
      end
      default: begin
        stall_c = 1'b1;
        state_d = RUN;
      end
    endcase
    // Exceptions arriving while busy are remembered and taken on re-entering RUN.
    if ((state_q != RUN) && exception_req) exc_pending_d = 1'b1;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      exc_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      exc_pending_q <= exc_pending_d;
    end
  end

  // While in reset both pipeline registers are held flushed and nothing advances.
  always_comb begin
    stall         = reset ? 1'b0 : stall_c;
    fetch_enable  = reset ? 1'b0 : fetch_c;
    pc_load       = reset ? 1'b0 : pc_load_c;
    flush_decode  = reset ? 1'b1 : flush_d_c;
    flush_execute = reset ? 1'b1 : flush_x_c;
    state         = state_q;
  end

`ifdef GBA_PIPE_PERF_EN
  logic [PERF_WIDTH-1:0] perf_stall_q, perf_flush_q;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + PERF_WIDTH'(1);
      if (pc_load && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + PERF_WIDTH'(1);
    end
  end

  assign perf_stall_count = perf_stall_q;
  assign perf_flush_count = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - table-driven bench for pipeline_controller
module tb_pipeline_controller;

  localparam int MW = 4;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          branch_taken = 1'b0;
  logic          exception_req = 1'b0;
  logic          multi_start = 1'b0;
  logic [MW-1:0] multi_cycles = '0;
  logic          mem_ready = 1'b1;
  logic          stall, fetch_enable, pc_load, flush_decode, flush_execute;
  logic [2:0]    state;
`ifdef GBA_PIPE_PERF_EN
  logic [PW-1:0] perf_stall_count, perf_flush_count;
`endif

  pipeline_controller #(.MULTI_WIDTH(MW), .PERF_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .branch_taken(branch_taken),
    .exception_req(exception_req), .multi_start(multi_start),
    .multi_cycles(multi_cycles), .mem_ready(mem_ready),
    .stall(stall), .fetch_enable(fetch_enable), .pc_load(pc_load),
    .flush_decode(flush_decode), .flush_execute(flush_execute), .state(state)
`ifdef GBA_PIPE_PERF_EN
    , .perf_stall_count(perf_stall_count), .perf_flush_count(perf_flush_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, br, exc, ms;
    logic [3:0] mc;
    logic       mr;
    logic       e_stall, e_fe, e_pcl, e_fd, e_fx;
    logic [2:0] e_state;
  } vec_t;

  vec_t vecs[$];
  int compared = 0;
  int mismatched = 0;

  task automatic add(input logic rst, br, exc, ms, input logic [3:0] mc, input logic mr,
                     input logic s, fe, pcl, fd, fx, input logic [2:0] st);
    vec_t v;
    v.rst = rst; v.br = br; v.exc = exc; v.ms = ms; v.mc = mc; v.mr = mr;
    v.e_stall = s; v.e_fe = fe; v.e_pcl = pcl; v.e_fd = fd; v.e_fx = fx; v.e_state = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Drive inputs just after the rising edge; state moves on the falling edge.
  task automatic drive(input logic rst, br, exc, ms, input logic [3:0] mc, input logic mr);
    @(posedge clock);
    #1;
    reset = rst; branch_taken = br; exception_req = exc;
    multi_start = ms; multi_cycles = mc; mem_ready = mr;
    #2;
  endtask

  initial begin
    int n;
    //   rst br ex ms mc mr | st fe pl fd fx state
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0);  // reset values
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);  // RUN idle
    add(0, 1, 0, 0, 0, 1,  0, 1, 1, 1, 1, 0);  // branch taken
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 3);  // REFILL1
    add(0, 1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 4);  // REFILL2, branch ignored
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);  // RUN
    add(0, 0, 0, 1, 3, 1,  0, 1, 0, 0, 0, 0);  // multi 3
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);  // exactly 3 stall cycles
    add(0, 0, 0, 1, 0, 1,  0, 1, 0, 0, 0, 0);  // multi 0 ignored
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2, 1,  0, 1, 0, 0, 0, 0);  // multi 2 with bus wait
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);  // 4 stall cycles total
    add(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);  // RUN, mem not ready
    add(0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1);  // MEMWAIT, exc+branch
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1);  // MEMWAIT exits
    add(0, 0, 0, 0, 0, 1,  0, 1, 1, 1, 1, 0);  // pending exception serviced
    add(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 3);  // REFILL1 held by bus
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 3);
    add(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4);  // REFILL2 held by bus
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);  // pending cleared
    add(0, 0, 1, 1, 3, 0,  0, 1, 1, 1, 1, 0);  // exception beats bus/multi
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0);  // reset mid-REFILL1
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 1, 1, 1, 0);  // branch beats !mem_ready
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 5, 1,  0, 1, 0, 0, 0, 0);  // multi 5
    add(0, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 2);  // exception in MULTI -> pending
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0);  // reset mid-MULTI
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);  // no pending retained

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].br, vecs[i].exc, vecs[i].ms, vecs[i].mc, vecs[i].mr);
      check("stall", i, 32'(stall), 32'(vecs[i].e_stall));
      check("fetch_enable", i, 32'(fetch_enable), 32'(vecs[i].e_fe));
      check("pc_load", i, 32'(pc_load), 32'(vecs[i].e_pcl));
      check("flush_decode", i, 32'(flush_decode), 32'(vecs[i].e_fd));
      check("flush_execute", i, 32'(flush_execute), 32'(vecs[i].e_fx));
      check("state", i, 32'(state), 32'(vecs[i].e_state));
    end

    // Maximum multi_cycles: count stall cycles with a bounded loop.
    drive(0, 0, 0, 1, 4'd15, 1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      if (!stall) break;
      n++;
    end
    check("multi15_stall_len", 100, 32'(n), 32'd15);
    check("multi15_back_to_run", 100, 32'(state), 32'd0);

`ifdef GBA_PIPE_PERF_EN
    drive(1, 0, 0, 0, 0, 1);
    check("perf_stall_reset", 200, 32'(perf_stall_count), 32'd0);
    check("perf_flush_reset", 200, 32'(perf_flush_count), 32'd0);
    for (int k = 0; k < (1 << PW) + 5; k++) drive(0, 0, 0, 0, 0, 0);
    check("perf_stall_sat", 201, 32'(perf_stall_count), 32'((1 << PW) - 1));
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("perf_flush_one", 202, 32'(perf_flush_count), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
